// File: rtl/cnn_conv3x3_pe.sv
// cnn_conv3x3_pe: 3x3 valid-convolution PE with programmable kernel and bias,
// followed by ReLU, arithmetic shift and unsigned saturation.
module cnn_conv3x3_pe #(
  parameter int DATA_WIDTH   = 8,
  parameter int WIDTH        = 28,
  parameter int HEIGHT       = 28,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 22,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_addr,
  input  logic [ACC_WIDTH-1:0]    cfg_data,
  input  logic [9*DATA_WIDTH-1:0] window_in,
  input  logic                    valid_in,
  output logic                    in_ready,
  output logic [OUT_WIDTH-1:0]    pixel_out,
  output logic                    valid_out,
  input  logic                    out_ready,
  output logic                    frame_done,
  output logic                    busy
);
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH + 1;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic signed [WEIGHT_WIDTH-1:0] w_q [9];
  logic signed [WEIGHT_WIDTH-1:0] w_d [9];
  logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
  logic signed [PW-1:0] prod_q [9];
  logic signed [PW-1:0] prod_d [9];
  logic signed [ACC_WIDTH-1:0] sum_q, sum_d, sh;
  logic [OUT_WIDTH-1:0] pix_q, pix_d;
  logic v1_q, v2_q, v3_q, l1_q, l2_q, l3_q;
  logic in_frame_q, in_frame_d;
  logic adv, acc, cfg_ok, col_wrap, row_wrap, last, tag;
  assign adv        = !(v3_q && !out_ready);
  assign in_ready   = adv;
  assign acc        = valid_in && adv;
  assign busy       = in_frame_q || v1_q || v2_q || v3_q;
  assign cfg_ok     = cfg_we && !busy;
  assign col_wrap   = col_q == CW'(WIDTH - 1);
  assign row_wrap   = row_q == RW'(HEIGHT - 1);
  assign last       = col_wrap && row_wrap;
  assign tag        = row_q >= RW'(2) && col_q >= CW'(2);
  assign sh         = sum_q >>> SHIFT;
  assign pixel_out  = pix_q;
  assign valid_out  = v3_q;
  assign frame_done = v3_q && out_ready && l3_q;
  always_comb begin
    col_d = !acc ? col_q : col_wrap ? '0 : col_q + 1'b1;
    row_d = !(acc && col_wrap) ? row_q : row_wrap ? '0 : row_q + 1'b1;
    in_frame_d = acc ? !last : in_frame_q;
    bias_d = (cfg_ok && cfg_addr == 4'd9) ? $signed(cfg_data) : bias_q;
    // Products use the next-state taps so a same-cycle write is already visible
    for (int k = 0; k < 9; k++) begin
      w_d[k] = (cfg_ok && cfg_addr == 4'(k)) ? $signed(cfg_data[WEIGHT_WIDTH-1:0]) : w_q[k];
      prod_d[k] = PW'($signed({1'b0, window_in[k*DATA_WIDTH +: DATA_WIDTH]})) * PW'(w_d[k]);
    end
    sum_d = bias_q;
    for (int k = 0; k < 9; k++) sum_d = sum_d + ACC_WIDTH'(prod_q[k]);
    pix_d = sum_q[ACC_WIDTH-1] ? '0
          : (sh > ACC_WIDTH'(2**OUT_WIDTH - 1)) ? {OUT_WIDTH{1'b1}}
          : sh[OUT_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      in_frame_q <= 1'b0;
      bias_q <= '0;
      for (int k = 0; k < 9; k++) begin
        w_q[k] <= '0;
        prod_q[k] <= '0;
      end
      sum_q <= '0;
      pix_q <= '0;
      {v1_q, v2_q, v3_q, l1_q, l2_q, l3_q} <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      in_frame_q <= in_frame_d;
      bias_q <= bias_d;
      w_q <= w_d;
      if (adv) begin
        prod_q <= prod_d;
        sum_q <= sum_d;
        pix_q <= pix_d;
        v1_q <= acc && tag;
        l1_q <= last;
        v2_q <= v1_q;
        l2_q <= l1_q;
        v3_q <= v2_q;
        l3_q <= l2_q;
      end
    end
  end
endmodule
